// File: rtl/sound_pkg.sv
// sound_pkg: codes shared between the sound sequencer and the sound card.
//   sound_t   : tone codes driven on `sound`
//   channel_t : channel codes driven on `channel` (CH_NONE mutes the card)
//   state_t   : sequencer FSM states
//   CLS_*     : event priority classes (goal > hit > wall)
//   event_t   : one decoded event (class plus the codes it plays)
//   event_desc: fixed table entry for event index 0..4, in tie-break order
package sound_pkg;

    typedef enum logic [1:0] {
        SND_NONE = 2'd0,
        SND_PING = 2'd1,
        SND_PONG = 2'd2,
        SND_GOAL = 2'd3
    } sound_t;

    typedef enum logic [1:0] {
        CH_NONE  = 2'd0,
        CH_RIGHT = 2'd1,
        CH_LEFT  = 2'd2,
        CH_BOTH  = 2'd3
    } channel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_WALL = 2'd0;
    localparam logic [1:0] CLS_HIT  = 2'd1;
    localparam logic [1:0] CLS_GOAL = 2'd2;

    // Event indices, lowest index wins a same-cycle tie.
    localparam int EV_GOAL_LEFT  = 0;
    localparam int EV_GOAL_RIGHT = 1;
    localparam int EV_HIT_LEFT   = 2;
    localparam int EV_HIT_RIGHT  = 3;
    localparam int EV_WALL       = 4;
    localparam int NUM_EVENTS    = 5;

    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        sound_t     snd;
        channel_t   ch;
    } event_t;

    localparam event_t EVENT_NONE = '{valid: 1'b0, cls: CLS_WALL,
                                      snd: SND_NONE, ch: CH_NONE};

    function automatic event_t event_desc(input int idx);
        event_t e;
        e       = EVENT_NONE;
        e.valid = 1'b1;
        case (idx)
            EV_GOAL_LEFT:  begin e.cls = CLS_GOAL; e.snd = SND_GOAL; e.ch = CH_LEFT;  end
            EV_GOAL_RIGHT: begin e.cls = CLS_GOAL; e.snd = SND_GOAL; e.ch = CH_RIGHT; end
            EV_HIT_LEFT:   begin e.cls = CLS_HIT;  e.snd = SND_PING; e.ch = CH_LEFT;  end
            EV_HIT_RIGHT:  begin e.cls = CLS_HIT;  e.snd = SND_PING; e.ch = CH_RIGHT; end
            default:       begin e.cls = CLS_WALL; e.snd = SND_PONG; e.ch = CH_BOTH;  end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sound_timer.sv
// sound_timer: unsigned down-counter used for both tone and gap durations.
//   snd_clk : clock
//   rst     : synchronous active-high reset
//   load    : load `value` (counter takes value-1)
//   value   : duration in cycles, must be >= 1
//   done    : registered pulse, high during the last cycle of the duration
// After a load at edge n, done is high in cycle n+value, so the caller's
// state lasts exactly `value` cycles if it reacts to done on that edge.
module sound_timer #(
    parameter int CNT_W = 20
) (
    input  logic             snd_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;

    always_ff @(posedge snd_clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else if (load) begin
            cnt_reg  <= value - CNT_W'(1);
            done_reg <= (value == CNT_W'(1));
        end else if (cnt_reg != '0) begin
            cnt_reg  <= cnt_reg - CNT_W'(1);
            done_reg <= (cnt_reg == CNT_W'(1));
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: turns one-cycle game events into timed sound/channel
// codes for the sound card, with goal multi-beep patterns, a one-deep
// pending slot and class-based preemption.
//   snd_clk    : clock
//   rst        : synchronous active-high reset
//   hit_left, hit_right, wall, goal_left, goal_right : one-cycle events
//   sound      : tone code (registered)
//   channel    : channel code (registered, CH_NONE whenever silent)
//   busy       : high whenever the sequencer is not idle (registered)
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int               CNT_W      = 20,
    parameter logic [CNT_W-1:0] TONE_LEN   = CNT_W'(600000),
    parameter logic [CNT_W-1:0] GAP_LEN    = CNT_W'(300000),
    parameter int               GOAL_BEEPS = 3
) (
    input  logic       snd_clk,
    input  logic       rst,
    input  logic       hit_left,
    input  logic       hit_right,
    input  logic       wall,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [1:0] sound,
    output logic [1:0] channel,
    output logic       busy
);

    localparam logic [2:0] BEEP_LIMIT = 3'(GOAL_BEEPS);

    // Event table, indexed in tie-break order.
    logic [NUM_EVENTS-1:0] ev_req;
    event_t                ev_tbl [NUM_EVENTS];

    assign ev_req = {wall, hit_right, hit_left, goal_right, goal_left};

    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
        assign ev_tbl[gi] = event_desc(gi);
    end

    // Registered state
    state_t   state_reg, state_next;
    event_t   cur_reg,   cur_next;
    event_t   pend_reg,  pend_next;
    logic [2:0] beep_reg, beep_next;
    sound_t   sound_reg, sound_next;
    channel_t channel_reg, channel_next;
    logic     busy_reg,  busy_next;

    // Timer control
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;

    sound_timer #(.CNT_W(CNT_W)) u_timer (
        .snd_clk (snd_clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .done    (tmr_done)
    );

    // Winner and runner-up of this cycle's events.
    event_t win, run;

    always_comb begin
        win = EVENT_NONE;
        run = EVENT_NONE;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (ev_req[i]) begin
                if (!win.valid)      win = ev_tbl[i];
                else if (!run.valid) run = ev_tbl[i];
            end
        end
    end

    // Next-state decision.
    logic   start;
    event_t pend_cand;
    event_t pend_eff;
    logic   store;

    always_comb begin
        // The winner starts playing when idle or when it outranks the
        // current tone; otherwise it competes for the pending slot. When
        // the winner starts, the runner-up of the same cycle gets that
        // chance instead, so a simultaneous lower event is not lost.
        start     = win.valid && ((state_reg == IDLE) || (win.cls > cur_reg.cls));
        pend_cand = start ? run : win;
        store     = pend_cand.valid &&
                    (!pend_reg.valid || (pend_cand.cls >= pend_reg.cls));
        pend_eff  = store ? pend_cand : pend_reg;

        state_next = state_reg;
        cur_next   = cur_reg;
        beep_next  = beep_reg;
        pend_next  = pend_eff;
        tmr_load   = 1'b0;
        tmr_value  = TONE_LEN;

        if (start) begin
            state_next = PLAY;
            cur_next   = win;
            beep_next  = 3'd1;
            tmr_load   = 1'b1;
        end else if (state_reg != IDLE && tmr_done) begin
            if (state_reg == PLAY) begin
                if (cur_reg.snd == SND_GOAL && beep_reg < BEEP_LIMIT) begin
                    state_next = GAP;
                    tmr_load   = 1'b1;
                    tmr_value  = GAP_LEN;
                end else if (pend_eff.valid) begin
                    // Chain straight into the pending tone, no idle cycle.
                    state_next = PLAY;
                    cur_next   = pend_eff;
                    pend_next  = EVENT_NONE;
                    beep_next  = 3'd1;
                    tmr_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                    cur_next   = EVENT_NONE;
                    beep_next  = 3'd0;
                end
            end else begin
                state_next = PLAY;
                beep_next  = beep_reg + 3'd1;
                tmr_load   = 1'b1;
            end
        end

        // Output codes follow the next state so they are registered with it.
        sound_next   = SND_NONE;
        channel_next = CH_NONE;
        busy_next    = (state_next != IDLE);
        if (state_next == PLAY) begin
            sound_next   = cur_next.snd;
            channel_next = cur_next.ch;
        end else if (state_next == GAP) begin
            // The card latches its last tone; channel alone mutes it.
            sound_next = SND_GOAL;
        end
    end

    always_ff @(posedge snd_clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cur_reg     <= EVENT_NONE;
            pend_reg    <= EVENT_NONE;
            beep_reg    <= 3'd0;
            sound_reg   <= SND_NONE;
            channel_reg <= CH_NONE;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_reg     <= cur_next;
            pend_reg    <= pend_next;
            beep_reg    <= beep_next;
            sound_reg   <= sound_next;
            channel_reg <= channel_next;
            busy_reg    <= busy_next;
        end
    end

    assign sound   = sound_reg;
    assign channel = channel_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed testbench for sound_sequencer with TONE_LEN=10, GAP_LEN=5,
// GOAL_BEEPS=3. Cycle c of a scenario is the clock period in which the
// stimulus for c is applied; outputs are sampled at the falling edge.
module tb_sound_sequencer;

    logic       snd_clk = 1'b0;
    logic       rst = 1'b1;
    logic       hit_left = 1'b0, hit_right = 1'b0, wall = 1'b0;
    logic       goal_left = 1'b0, goal_right = 1'b0;
    logic [1:0] sound, channel;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    logic [4:0] obs;

    localparam logic [4:0] E_GL = 5'b10000;
    localparam logic [4:0] E_GR = 5'b01000;
    localparam logic [4:0] E_HL = 5'b00100;
    localparam logic [4:0] E_HR = 5'b00010;
    localparam logic [4:0] E_WL = 5'b00001;

    sound_sequencer #(
        .CNT_W      (20),
        .TONE_LEN   (20'd10),
        .GAP_LEN    (20'd5),
        .GOAL_BEEPS (3)
    ) dut (
        .snd_clk    (snd_clk),
        .rst        (rst),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .wall       (wall),
        .goal_left  (goal_left),
        .goal_right (goal_right),
        .sound      (sound),
        .channel    (channel),
        .busy       (busy)
    );

    always #5 snd_clk = ~snd_clk;

    // Sample outputs for this cycle, then apply this cycle's inputs.
    task automatic tick(input logic r, input logic [4:0] ev);
        @(negedge snd_clk);
        obs = {sound, channel, busy};
        rst = r;
        {goal_left, goal_right, hit_left, hit_right, wall} = ev;
    endtask

    task automatic clean_start();
        tick(1'b1, 5'b0);
        tick(1'b0, 5'b0);
    endtask

    task automatic test_reset();
        // Events asserted together with rst must be ignored.
        tick(1'b1, E_HL | E_WL | E_GR);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 5'b0);
            vectors++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got s=%0d ch=%0d busy=%0d, want s=0 ch=0 busy=0",
                         c, obs[4:3], obs[2:1], obs[0]);
            end
        end
    endtask

    task automatic test_single_hit();
        logic [4:0] exp_v;
        clean_start();
        for (int c = 0; c < 14; c++) begin
            tick(1'b0, (c == 0) ? E_HL : 5'b0);
            exp_v = (c >= 1 && c <= 10) ? {2'd1, 2'd2, 1'b1} : 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single_hit cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_goal();
        logic [4:0] exp_v;
        clean_start();
        for (int c = 0; c < 44; c++) begin
            tick(1'b0, (c == 0) ? E_GR : 5'b0);
            if (c >= 1 && c <= 40)
                exp_v = (((c - 1) % 15) < 10) ? {2'd3, 2'd1, 1'b1} : {2'd3, 2'd0, 1'b1};
            else
                exp_v = 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL goal cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_preempt();
        logic [4:0] exp_v;
        logic [4:0] ev;
        clean_start();
        for (int c = 0; c < 20; c++) begin
            ev = (c == 0) ? E_WL : ((c == 3) ? E_HR : 5'b0);
            tick(1'b0, ev);
            if (c >= 1 && c <= 3)       exp_v = {2'd2, 2'd3, 1'b1};
            else if (c >= 4 && c <= 13) exp_v = {2'd1, 2'd1, 1'b1};
            else                        exp_v = 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL preempt cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_v;
        logic [4:0] ev;
        clean_start();
        for (int c = 0; c < 25; c++) begin
            ev = (c == 0) ? E_HL : ((c == 2) ? E_WL : ((c == 4) ? E_HR : 5'b0));
            tick(1'b0, ev);
            if (c >= 1 && c <= 10)       exp_v = {2'd1, 2'd2, 1'b1};
            else if (c >= 11 && c <= 20) exp_v = {2'd1, 2'd1, 1'b1};
            else                         exp_v = 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_v;
        clean_start();
        for (int c = 0; c < 54; c++) begin
            tick(1'b0, (c == 0) ? (E_GL | E_HL | E_WL) : 5'b0);
            if (c >= 1 && c <= 40)
                exp_v = (((c - 1) % 15) < 10) ? {2'd3, 2'd2, 1'b1} : {2'd3, 2'd0, 1'b1};
            else if (c >= 41 && c <= 50)
                exp_v = {2'd1, 2'd2, 1'b1};
            else
                exp_v = 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        logic [4:0] exp_v;
        logic [4:0] ev;
        clean_start();
        for (int c = 0; c < 30; c++) begin
            // hit_left at 5 sits in pending; reset at 12 must clear it.
            ev = (c == 0) ? E_GR : ((c == 5) ? E_HL : ((c == 12) ? E_HR : 5'b0));
            tick(c == 12, ev);
            if (c >= 1 && c <= 10)       exp_v = {2'd3, 2'd1, 1'b1};
            else if (c >= 11 && c <= 12) exp_v = {2'd3, 2'd0, 1'b1};
            else                         exp_v = 5'b0;
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_gap cycle %0d: got s=%0d ch=%0d busy=%0d, want s=%0d ch=%0d busy=%0d",
                         c, obs[4:3], obs[2:1], obs[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge snd_clk);
        test_reset();
        test_single_hit();
        test_goal();
        test_preempt();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
